// File: rtl/score_pkg.sv
// Shared game-state encoding and default configuration for the score keeper.
// No backpressure or timing of its own: types and constants only.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        COMMIT = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DW         = 4;
    localparam int DEF_STREAK_LEN = 4;
    localparam int DEF_BONUS      = 2;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder, purely combinational (zero latency).
// No backpressure: output follows inputs; clipped flags a sum pinned at all-ones.
module sat_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             clipped
);

    logic [WIDTH:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b};
        clipped  = full_sum[WIDTH];
        sum      = clipped ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
    end

endmodule

// File: rtl/score_keeper.sv
// Game score FSM (IDLE/PLAY/COMMIT/OVER), registered outputs; HI/NEW_HI settle within two edges of END.
// No backpressure: event pulses sampled every cycle; streak bonus only with SCORE_KEEPER_STREAK_BONUS_EN.
module score_keeper
    import score_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DW         = DEF_DW,
    parameter int STREAK_LEN = DEF_STREAK_LEN,
    parameter int BONUS      = DEF_BONUS
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             START,
    input  logic             END,
    input  logic             LD,
    input  logic             MISS,
    input  logic [DW-1:0]    D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] HI,
    output logic             SAT,
    output logic             NEW_HI,
    output logic             PLAYING
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] score_q, score_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             sat_q, sat_d;
    logic             new_hi_q, new_hi_d;
    logic             playing_q, playing_d;

    logic             game_start;
    logic [WIDTH-1:0] pts_ext;
    logic [WIDTH-1:0] bonus_amt;
    logic [WIDTH-1:0] pts_sum, total_sum;
    logic             pts_clip, bonus_clip;

    assign game_start = START && (state_q == IDLE || state_q == OVER);
    assign pts_ext    = WIDTH'(D);

    // Two chained saturating adds equal one saturating add of D+BONUS,
    // and keep D+BONUS itself from wrapping.
    sat_add #(.WIDTH(WIDTH)) u_add_pts (
        .a       (score_q),
        .b       (pts_ext),
        .sum     (pts_sum),
        .clipped (pts_clip)
    );

    sat_add #(.WIDTH(WIDTH)) u_add_bonus (
        .a       (pts_sum),
        .b       (bonus_amt),
        .sum     (total_sum),
        .clipped (bonus_clip)
    );

`ifdef SCORE_KEEPER_STREAK_BONUS_EN
    logic [3:0] streak_q, streak_d;
    logic       bonus_hit;

    assign bonus_hit = LD && !MISS && (streak_q == 4'(STREAK_LEN - 1));
    assign bonus_amt = bonus_hit ? WIDTH'(BONUS) : '0;

    always_comb begin
        streak_d = streak_q;
        if (game_start) begin
            streak_d = '0;
        end else if (state_q == PLAY) begin
            if (MISS || bonus_hit) begin
                streak_d = '0;
            end else if (LD) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    logic unused_cfg;

    assign bonus_amt  = '0;
    assign unused_cfg = MISS ^ (STREAK_LEN > 0) ^ (BONUS > 0);
`endif

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        hi_d     = hi_q;
        sat_d    = sat_q;
        new_hi_d = new_hi_q;

        case (state_q)
            IDLE, OVER: begin
                if (START) begin
                    state_d  = PLAY;
                    score_d  = '0;
                    sat_d    = 1'b0;
                    new_hi_d = 1'b0;
                end
            end
            PLAY: begin
                if (LD) begin
                    score_d = total_sum;
                    if (pts_clip || bonus_clip) begin
                        sat_d = 1'b1;
                    end
                end
                if (END) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // A tie with the standing high score is not a new high.
                if (score_q > hi_q) begin
                    hi_d     = score_q;
                    new_hi_d = 1'b1;
                end else begin
                    new_hi_d = 1'b0;
                end
                state_d = OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        playing_d = (state_d == PLAY);
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q   <= IDLE;
            score_q   <= '0;
            hi_q      <= '0;
            sat_q     <= 1'b0;
            new_hi_q  <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            hi_q      <= hi_d;
            sat_q     <= sat_d;
            new_hi_q  <= new_hi_d;
            playing_q <= playing_d;
        end
    end

    assign Q       = score_q;
    assign HI      = hi_q;
    assign SAT     = sat_q;
    assign NEW_HI  = new_hi_q;
    assign PLAYING = playing_q;

endmodule
